decode_stage: RTL and testbench

//  RV32I instruction decode pipeline stage. Produces the alucode and operand selects consumed by the ALU.

---
 rtl/decode_stage.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode pipeline stage with registered valid/ready output
//
// Purpose: decodes {pc, insn} from fetch into the ALU operation code, operand
// selects, register indices, immediate and load/store/illegal flags, and
// presents the bundle one cycle later on a registered valid/ready output.
// A taken branch (flush) kills all held and incoming work.
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   in_valid/in_ready         fetch handshake carrying in_pc, in_insn
//   flush                     ALU br_taken; drops held bundles and the insn accepted this cycle
//   out_valid/out_ready       downstream handshake carrying the out_* bundle
//   out_alucode               ALU operation code (ALU_NOP when illegal)
//   out_op1_type/op2_type     0=REG 1=IMM 2=PC 3=NONE
//   out_rs1/rs2/rd            register indices, 0 when the format lacks the field
//   out_imm, out_pc           sign-extended immediate, pc of the bundle
//   out_reg_we                rd write enable, never set for rd==0
//   out_is_load/is_store      memory access class
//   out_illegal               unsupported opcode/funct
//
// Build option: DECODE_SKID_EN adds a one-entry skid buffer so that in_ready
// is a register (no combinational path from out_ready).
module decode_stage #(
   parameter int W_DATA    = 32,
   parameter int W_ALUCODE = 6
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W_DATA-1:0]    in_pc,
   input  logic [W_DATA-1:0]    in_insn,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W_ALUCODE-1:0] out_alucode,
   output logic [1:0]           out_op1_type,
   output logic [1:0]           out_op2_type,
   output logic [4:0]           out_rs1,
   output logic [4:0]           out_rs2,
   output logic [4:0]           out_rd,
   output logic [W_DATA-1:0]    out_imm,
   output logic [W_DATA-1:0]    out_pc,
   output logic                 out_reg_we,
   output logic                 out_is_load,
   output logic                 out_is_store,
   output logic                 out_illegal
);

   localparam logic [W_ALUCODE-1:0] ALU_NOP  = W_ALUCODE'(0);
   localparam logic [W_ALUCODE-1:0] ALU_ADD  = W_ALUCODE'(1);
   localparam logic [W_ALUCODE-1:0] ALU_SUB  = W_ALUCODE'(2);
   localparam logic [W_ALUCODE-1:0] ALU_SLT  = W_ALUCODE'(3);
   localparam logic [W_ALUCODE-1:0] ALU_SLTU = W_ALUCODE'(4);
   localparam logic [W_ALUCODE-1:0] ALU_XOR  = W_ALUCODE'(5);
   localparam logic [W_ALUCODE-1:0] ALU_OR   = W_ALUCODE'(6);
   localparam logic [W_ALUCODE-1:0] ALU_AND  = W_ALUCODE'(7);
   localparam logic [W_ALUCODE-1:0] ALU_SLL  = W_ALUCODE'(8);
   localparam logic [W_ALUCODE-1:0] ALU_SRL  = W_ALUCODE'(9);
   localparam logic [W_ALUCODE-1:0] ALU_SRA  = W_ALUCODE'(10);
   localparam logic [W_ALUCODE-1:0] ALU_LUI  = W_ALUCODE'(11);
   localparam logic [W_ALUCODE-1:0] ALU_JAL  = W_ALUCODE'(12);
   localparam logic [W_ALUCODE-1:0] ALU_JALR = W_ALUCODE'(13);
   localparam logic [W_ALUCODE-1:0] ALU_BEQ  = W_ALUCODE'(14);
   localparam logic [W_ALUCODE-1:0] ALU_BNE  = W_ALUCODE'(15);
   localparam logic [W_ALUCODE-1:0] ALU_BLT  = W_ALUCODE'(16);
   localparam logic [W_ALUCODE-1:0] ALU_BGE  = W_ALUCODE'(17);
   localparam logic [W_ALUCODE-1:0] ALU_BLTU = W_ALUCODE'(18);
   localparam logic [W_ALUCODE-1:0] ALU_BGEU = W_ALUCODE'(19);
   localparam logic [W_ALUCODE-1:0] ALU_LB   = W_ALUCODE'(20);
   localparam logic [W_ALUCODE-1:0] ALU_LH   = W_ALUCODE'(21);
   localparam logic [W_ALUCODE-1:0] ALU_LW   = W_ALUCODE'(22);
   localparam logic [W_ALUCODE-1:0] ALU_LBU  = W_ALUCODE'(23);
   localparam logic [W_ALUCODE-1:0] ALU_LHU  = W_ALUCODE'(24);
   localparam logic [W_ALUCODE-1:0] ALU_SB   = W_ALUCODE'(25);
   localparam logic [W_ALUCODE-1:0] ALU_SH   = W_ALUCODE'(26);
   localparam logic [W_ALUCODE-1:0] ALU_SW   = W_ALUCODE'(27);

   localparam logic [1:0] OPD_REG  = 2'd0;
   localparam logic [1:0] OPD_IMM  = 2'd1;
   localparam logic [1:0] OPD_PC   = 2'd2;
   localparam logic [1:0] OPD_NONE = 2'd3;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef struct packed {
      logic [W_ALUCODE-1:0] alucode;
      logic [1:0]           op1_type;
      logic [1:0]           op2_type;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [4:0]           rd;
      logic [W_DATA-1:0]    imm;
      logic [W_DATA-1:0]    pc;
      logic                 reg_we;
      logic                 is_load;
      logic                 is_store;
      logic                 illegal;
   } bundle_t;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = in_insn[6:0];
   assign f3     = in_insn[14:12];
   assign f7     = in_insn[31:25];
   assign imm_i  = {{20{in_insn[31]}}, in_insn[31:20]};
   assign imm_s  = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
   assign imm_b  = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
   assign imm_u  = {in_insn[31:12], 12'b0};
   assign imm_j  = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};

   bundle_t dec;
   logic    legal;
   logic    writes_rd;

   always_comb begin
      dec       = '0;
      legal     = 1'b1;
      writes_rd = 1'b0;
      dec.pc    = in_pc;
      case (opcode)
         OPC_OP: begin
            dec.rs1 = in_insn[19:15]; dec.rs2 = in_insn[24:20]; dec.rd = in_insn[11:7];
            dec.op1_type = OPD_REG; dec.op2_type = OPD_REG; writes_rd = 1'b1;
            case ({f7, f3})
               10'b0000000_000: dec.alucode = ALU_ADD;
               10'b0000000_001: dec.alucode = ALU_SLL;
               10'b0000000_010: dec.alucode = ALU_SLT;
               10'b0000000_011: dec.alucode = ALU_SLTU;
               10'b0000000_100: dec.alucode = ALU_XOR;
               10'b0000000_101: dec.alucode = ALU_SRL;
               10'b0000000_110: dec.alucode = ALU_OR;
               10'b0000000_111: dec.alucode = ALU_AND;
               10'b0100000_000: dec.alucode = ALU_SUB;
               10'b0100000_101: dec.alucode = ALU_SRA;
               default:         legal = 1'b0;
            endcase
         end
         OPC_OPIMM: begin
            dec.rs1 = in_insn[19:15]; dec.rd = in_insn[11:7]; dec.imm = imm_i;
            dec.op1_type = OPD_REG; dec.op2_type = OPD_IMM; writes_rd = 1'b1;
            case (f3)
               3'b000: dec.alucode = ALU_ADD;
               3'b010: dec.alucode = ALU_SLT;
               3'b011: dec.alucode = ALU_SLTU;
               3'b100: dec.alucode = ALU_XOR;
               3'b110: dec.alucode = ALU_OR;
               3'b111: dec.alucode = ALU_AND;
               // shift-immediates reuse the funct7 slot, so it must be a valid shift kind
               3'b001: if (f7 == 7'b0000000) dec.alucode = ALU_SLL; else legal = 1'b0;
               default: begin
                  if (f7 == 7'b0000000)      dec.alucode = ALU_SRL;
                  else if (f7 == 7'b0100000) dec.alucode = ALU_SRA;
                  else                       legal = 1'b0;
               end
            endcase
         end
         OPC_LUI: begin
            dec.rd = in_insn[11:7]; dec.imm = imm_u; dec.alucode = ALU_LUI;
            dec.op1_type = OPD_NONE; dec.op2_type = OPD_IMM; writes_rd = 1'b1;
         end
         OPC_AUIPC: begin
            dec.rd = in_insn[11:7]; dec.imm = imm_u; dec.alucode = ALU_ADD;
            dec.op1_type = OPD_PC; dec.op2_type = OPD_IMM; writes_rd = 1'b1;
         end
         OPC_JAL: begin
            dec.rd = in_insn[11:7]; dec.imm = imm_j; dec.alucode = ALU_JAL;
            dec.op1_type = OPD_NONE; dec.op2_type = OPD_PC; writes_rd = 1'b1;
         end
         OPC_JALR: begin
            dec.rs1 = in_insn[19:15]; dec.rd = in_insn[11:7]; dec.imm = imm_i; dec.alucode = ALU_JALR;
            dec.op1_type = OPD_REG; dec.op2_type = OPD_PC; writes_rd = 1'b1;
            legal = (f3 == 3'b000);
         end
         OPC_BRANCH: begin
            dec.rs1 = in_insn[19:15]; dec.rs2 = in_insn[24:20]; dec.imm = imm_b;
            dec.op1_type = OPD_REG; dec.op2_type = OPD_REG;
            case (f3)
               3'b000:  dec.alucode = ALU_BEQ;
               3'b001:  dec.alucode = ALU_BNE;
               3'b100:  dec.alucode = ALU_BLT;
               3'b101:  dec.alucode = ALU_BGE;
               3'b110:  dec.alucode = ALU_BLTU;
               3'b111:  dec.alucode = ALU_BGEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            dec.rs1 = in_insn[19:15]; dec.rd = in_insn[11:7]; dec.imm = imm_i;
            dec.op1_type = OPD_REG; dec.op2_type = OPD_IMM; dec.is_load = 1'b1; writes_rd = 1'b1;
            case (f3)
               3'b000:  dec.alucode = ALU_LB;
               3'b001:  dec.alucode = ALU_LH;
               3'b010:  dec.alucode = ALU_LW;
               3'b100:  dec.alucode = ALU_LBU;
               3'b101:  dec.alucode = ALU_LHU;
               default: legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            dec.rs1 = in_insn[19:15]; dec.rs2 = in_insn[24:20]; dec.imm = imm_s;
            dec.op1_type = OPD_REG; dec.op2_type = OPD_IMM; dec.is_store = 1'b1;
            case (f3)
               3'b000:  dec.alucode = ALU_SB;
               3'b001:  dec.alucode = ALU_SH;
               3'b010:  dec.alucode = ALU_SW;
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      dec.reg_we = writes_rd && (dec.rd != 5'd0);
      // an illegal word carries only its pc and the flag, so nothing downstream acts on it
      if (!legal) begin
         dec         = '0;
         dec.pc      = in_pc;
         dec.illegal = 1'b1;
      end
   end

   bundle_t out_q;
   logic    out_valid_q;

`ifdef DECODE_SKID_EN
   bundle_t skid_q;
   logic    skid_full;
   logic    accept;

   assign in_ready = !skid_full;
   assign accept   = in_valid && !skid_full;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         skid_q      <= '0;
         skid_full   <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_full   <= 1'b0;
      end else if (!out_valid_q || out_ready) begin
         // output slot frees up: an older skid entry always goes first
         if (skid_full) begin
            out_q       <= skid_q;
            out_valid_q <= 1'b1;
            skid_full   <= 1'b0;
         end else if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_q    <= dec;
         skid_full <= 1'b1;
      end
   end
`else
   assign in_ready = !out_valid_q || out_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_q       <= dec;
         out_valid_q <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

   assign out_valid    = out_valid_q;
   assign out_alucode  = out_q.alucode;
   assign out_op1_type = out_q.op1_type;
   assign out_op2_type = out_q.op2_type;
   assign out_rs1      = out_q.rs1;
   assign out_rs2      = out_q.rs2;
   assign out_rd       = out_q.rd;
   assign out_imm      = out_q.imm;
   assign out_pc       = out_q.pc;
   assign out_reg_we   = out_q.reg_we;
   assign out_is_load  = out_q.is_load;
   assign out_is_store = out_q.is_store;
   assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard testbench for decode_stage
module tb_decode_stage;

   localparam int A_NOP = 0,  A_ADD = 1,  A_SUB = 2,  A_SLT = 3,  A_SLTU = 4, A_XOR = 5;
   localparam int A_OR  = 6,  A_AND = 7,  A_SLL = 8,  A_SRL = 9,  A_SRA = 10, A_LUI = 11;
   localparam int A_JAL = 12, A_JALR = 13, A_BEQ = 14;
   localparam int T_REG = 0, T_IMM = 1, T_PC = 2, T_NONE = 3;

   // funct3-indexed lookup tables; -1 marks an unsupported funct3
   int r_tab [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
   int b_tab [8] = '{14, 15, -1, -1, 16, 17, 18, 19};
   int l_tab [8] = '{20, 21, 22, -1, 23, 24, -1, -1};
   int s_tab [8] = '{25, 26, 27, -1, -1, -1, -1, -1};

   typedef struct packed {
      logic [5:0]  alu;
      logic [1:0]  op1, op2;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm, pc;
      logic        we, ld, st, ill;
   } exp_t;

   logic clk = 1'b0, nrst = 1'b0;
   logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
   logic [31:0] in_pc = '0, in_insn = '0, out_imm, out_pc;
   logic [5:0] out_alucode;
   logic [1:0] out_op1_type, out_op2_type;
   logic [4:0] out_rs1, out_rs2, out_rd;
   logic out_reg_we, out_is_load, out_is_store, out_illegal;

   int   checks = 0, errors = 0;
   exp_t q[$];
   exp_t none = '0;

   decode_stage #(.W_DATA(32), .W_ALUCODE(6)) dut (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_insn(in_insn), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_alucode(out_alucode),
      .out_op1_type(out_op1_type), .out_op2_type(out_op2_type),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_pc(out_pc), .out_reg_we(out_reg_we),
      .out_is_load(out_is_load), .out_is_store(out_is_store), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   function automatic exp_t got();
      return {out_alucode, out_op1_type, out_op2_type, out_rs1, out_rs2, out_rd,
              out_imm, out_pc, out_reg_we, out_is_load, out_is_store, out_illegal};
   endfunction

   function automatic exp_t mk(int alu, int o1, int o2, int r1, int r2, int rd,
                               logic [31:0] imm, logic [31:0] pc, logic we);
      exp_t e;
      e = '0;
      e.alu = 6'(alu); e.op1 = 2'(o1); e.op2 = 2'(o2);
      e.rs1 = 5'(r1); e.rs2 = 5'(r2); e.rd = 5'(rd);
      e.imm = imm; e.pc = pc; e.we = we;
      return e;
   endfunction

   // Reference decoder: immediates by signed arithmetic, ALU codes by table lookup.
   function automatic exp_t model(logic [31:0] pc, logic [31:0] insn);
      exp_t e;
      logic signed [31:0] s;
      logic [31:0] hi, ii, is_, ib, iu, ij;
      int f3, f7, code, r1, r2, rd;
      bit wr;
      s  = $signed(insn);
      f3 = int'(insn[14:12]); f7 = int'(insn[31:25]);
      r1 = int'(insn[19:15]); r2 = int'(insn[24:20]); rd = int'(insn[11:7]);
      ii  = s >>> 20;
      hi  = s >>> 25; is_ = (hi << 5) + 32'(insn[11:7]);
      hi  = s >>> 31; ib  = (hi << 12) + (32'(insn[7]) << 11) + (32'(insn[30:25]) << 5) + (32'(insn[11:8]) << 1);
      iu  = insn & 32'hFFFFF000;
      ij  = (hi << 20) + (32'(insn[19:12]) << 12) + (32'(insn[20]) << 11) + (32'(insn[30:21]) << 1);
      code = -1; wr = 1'b0;
      e = '0;
      case (insn[6:0])
         7'h33: begin
            if (f7 == 0) code = r_tab[f3];
            else if (f7 == 32 && f3 == 0) code = A_SUB;
            else if (f7 == 32 && f3 == 5) code = A_SRA;
            e = mk(0, T_REG, T_REG, r1, r2, rd, 0, pc, 0); wr = 1;
         end
         7'h13: begin
            if (f3 == 1) code = (f7 == 0) ? A_SLL : -1;
            else if (f3 == 5) code = (f7 == 0) ? A_SRL : (f7 == 32) ? A_SRA : -1;
            else code = r_tab[f3];
            e = mk(0, T_REG, T_IMM, r1, 0, rd, ii, pc, 0); wr = 1;
         end
         7'h37: begin code = A_LUI; e = mk(0, T_NONE, T_IMM, 0, 0, rd, iu, pc, 0); wr = 1; end
         7'h17: begin code = A_ADD; e = mk(0, T_PC, T_IMM, 0, 0, rd, iu, pc, 0); wr = 1; end
         7'h6f: begin code = A_JAL; e = mk(0, T_NONE, T_PC, 0, 0, rd, ij, pc, 0); wr = 1; end
         7'h67: begin
            code = (f3 == 0) ? A_JALR : -1;
            e = mk(0, T_REG, T_PC, r1, 0, rd, ii, pc, 0); wr = 1;
         end
         7'h63: begin code = b_tab[f3]; e = mk(0, T_REG, T_REG, r1, r2, 0, ib, pc, 0); end
         7'h03: begin code = l_tab[f3]; e = mk(0, T_REG, T_IMM, r1, 0, rd, ii, pc, 0); e.ld = 1; wr = 1; end
         7'h23: begin code = s_tab[f3]; e = mk(0, T_REG, T_IMM, r1, r2, 0, is_, pc, 0); e.st = 1; end
         default: code = -1;
      endcase
      if (code < 0) begin
         e = '0; e.pc = pc; e.ill = 1'b1;
      end else begin
         e.alu = 6'(code);
         e.we  = wr && (rd != 0);
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_insn();
      logic [31:0] x;
      int k;
      x = $urandom;
      k = $urandom_range(0, 10);
      case (k)
         0: x[6:0] = 7'h33;  1: x[6:0] = 7'h13;  2: x[6:0] = 7'h37;
         3: x[6:0] = 7'h17;  4: x[6:0] = 7'h6f;  5: x[6:0] = 7'h67;
         6: x[6:0] = 7'h63;  7: x[6:0] = 7'h03;  8: x[6:0] = 7'h23;
         default: ;
      endcase
      if ($urandom_range(0, 3) != 0) x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      return x;
   endfunction

   // Monitor: compares whatever the DUT presents against the scoreboard head.
   always @(negedge clk) begin
      if (nrst) begin
         logic exp_rdy;
`ifdef DECODE_SKID_EN
         exp_rdy = (q.size() < 2);
`else
         exp_rdy = (q.size() == 0) || out_ready;
`endif
         checks++;
         if (out_valid !== (q.size() > 0)) begin
            errors++;
            $display("FAIL out_valid got=%b want=%b t=%0t", out_valid, q.size() > 0, $time);
         end
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready got=%b want=%b t=%0t", in_ready, exp_rdy, $time);
         end
         if (out_valid && q.size() > 0) begin
            checks++;
            if (got() !== q[0]) begin
               errors++;
               $display("FAIL bundle got=%h want=%h t=%0t", got(), q[0], $time);
            end
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   // One clock of stimulus; bookkeeping happens after the monitor has sampled.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                        input logic ordy, input logic fl, input logic use_e, input exp_t e,
                        output logic acc);
      @(posedge clk); #1;
      in_valid = v; in_pc = pc; in_insn = insn; out_ready = ordy; flush = fl;
      #6;
      acc = in_valid && in_ready;
      if (fl) q.delete();
      else if (acc) q.push_back(use_e ? e : model(pc, insn));
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 0, 0, 1, 0, 0, none, acc);
      cycle(0, 0, 0, 1, 0, 0, none, acc);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   stall;
      logic [31:0] ins [4];

      #2;
      checks++;
      if (out_valid !== 1'b0 || got() !== exp_t'('0)) begin
         errors++;
         $display("FAIL reset_state got v=%b %h want v=0 0", out_valid, got());
      end
      @(posedge clk); #1 nrst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end

      // directed decodes with hand-derived expectations
      cycle(1, 32'h100, 32'hFFF10093, 1, 0, 1, mk(A_ADD, T_REG, T_IMM, 2, 0, 1, 32'hFFFFFFFF, 32'h100, 1), acc);
      cycle(1, 32'h104, 32'hFE208EE3, 1, 0, 1, mk(A_BEQ, T_REG, T_REG, 1, 2, 0, 32'hFFFFFFFC, 32'h104, 0), acc);
      cycle(1, 32'h108, 32'h00000013, 1, 0, 1, mk(A_ADD, T_REG, T_IMM, 0, 0, 0, 32'h0, 32'h108, 0), acc);
      begin
         exp_t e;
         e = '0; e.pc = 32'h10C; e.ill = 1'b1;
         cycle(1, 32'h10C, 32'hFFFFFFFF, 1, 0, 1, e, acc);
      end
      cycle(1, 32'h110, 32'h123450B7, 1, 0, 1, mk(A_LUI, T_NONE, T_IMM, 0, 0, 1, 32'h12345000, 32'h110, 1), acc);
      drain();

      // 3-cycle downstream stall with 4 back-to-back instructions held until taken
      ins[0] = 32'h00108093; ins[1] = 32'h40208133; ins[2] = 32'h0000A183; ins[3] = 32'h00312223;
      stall = 0;
      for (int i = 0; i < 4; i++) begin
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++) begin
            cycle(1, 32'h200 + 32'(4 * i), ins[i], stall >= 3, 0, 0, none, acc);
            stall++;
         end
         checks++;
         if (!acc) begin
            errors++;
            $display("FAIL stall_accept idx=%0d got=timeout want=accepted", i);
         end
      end
      drain();

      // flush with a held bundle and an incoming insn, with and without downstream ready
      for (int r = 0; r < 2; r++) begin
         cycle(1, 32'h300, 32'h00500293, 0, 0, 0, none, acc);
         cycle(1, 32'h304, 32'h00600313, r[0], 1, 0, none, acc);
         cycle(0, 0, 0, 0, 0, 0, none, acc);
         cycle(0, 0, 0, 1, 0, 0, none, acc);
      end
      drain();

      // asynchronous reset in the middle of a stall
      cycle(1, 32'h400, 32'h00708393, 0, 0, 0, none, acc);
      cycle(1, 32'h404, 32'h00808413, 0, 0, 0, none, acc);
      nrst = 1'b0;
      q.delete();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_alucode !== 6'd0) begin
         errors++;
         $display("FAIL async_reset got v=%b alu=%0d want v=0 alu=0", out_valid, out_alucode);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; nrst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_in_ready got=%b want=1", in_ready);
      end
      cycle(1, 32'h408, 32'hFFF10093, 1, 0, 1, mk(A_ADD, T_REG, T_IMM, 2, 0, 1, 32'hFFFFFFFF, 32'h408, 1), acc);
      drain();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 9) < 7, $urandom, rand_insn(), $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0, 0, none, acc);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
